// File: rtl/dmem_wbuf.sv
// ---------------------------------------------------------------------------
// dmem_wbuf -- posted-store write buffer for the processor data port
//
// Stores go into a DEPTH-entry FIFO and are written to memory in order over
// a req/ack interface. The core stalls on a store only when the FIFO is full.
// Loads that miss every queued store go straight to memory, ahead of pending
// drains. Loads that hit a queued store either wait until that store has
// drained, or are forwarded from the buffer (see the option below).
//
// Optional feature macro: DMEM_WBUF_FWD_EN
//   defined   - a load whose youngest matching entry has all four byte
//               enables set returns that entry's data in the same cycle,
//               with no stall and no memory access
//   undefined - any match stalls the load until the match has drained; no
//               forwarding logic is built
//
// Parameters
//   DEPTH      FIFO entries, power of two in 2..16
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset, clears all state
//   cpu_wr     store request (held while cpu_stall=1)
//   cpu_rd     load request (held while cpu_stall=1); ignored if cpu_wr=1
//   cpu_addr   word address [31:2]
//   cpu_wdata  store data
//   cpu_be     store byte enables, bit i = byte lane i
//   cpu_rdata  load data, valid when cpu_rd=1 and cpu_stall=0
//   cpu_stall  combinational stall to the core
//   mem_req    memory transaction valid (registered)
//   mem_we     1=write, 0=read (registered)
//   mem_addr   memory word address (registered)
//   mem_wdata  write data (registered)
//   mem_be     write byte enables, 4'b1111 on reads (registered)
//   mem_ack    single-cycle completion pulse from memory
//   mem_rdata  read data, valid with mem_ack on reads
//   count      occupied FIFO entries (registered)
// ---------------------------------------------------------------------------
module dmem_wbuf #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_wr,
   input  logic                   cpu_rd,
   input  logic [29:0]            cpu_addr,
   input  logic [31:0]            cpu_wdata,
   input  logic [3:0]             cpu_be,
   output logic [31:0]            cpu_rdata,
   output logic                   cpu_stall,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [29:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_be,
   input  logic                   mem_ack,
   input  logic [31:0]            mem_rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // FIFO storage. Every entry has to be compared against the load address
   // each cycle, so the storage is kept in flops rather than a RAM.
   logic [29:0] addr_reg [DEPTH];
   logic [31:0] data_reg [DEPTH];
   logic [3:0]  be_reg   [DEPTH];

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg, count_next;

   logic        mem_req_reg,   mem_req_next;
   logic        mem_we_reg,    mem_we_next;
   logic [29:0] mem_addr_reg,  mem_addr_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic [3:0]  mem_be_reg,    mem_be_next;

   logic             full;
   logic             push;
   logic             pop;
   logic             load_active;
   logic             read_done;
   logic             need_read;
   logic             any_match;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic [DEPTH-1:0] entry_valid;
   logic [DEPTH-1:0] match;

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   // Fullness is judged on the registered count only: a pop in the same
   // cycle does not let a store in early.
   assign full        = (count_reg == CW'(DEPTH));
   assign push        = cpu_wr && !full;
   // A simultaneous store wins; the load is simply not looked at.
   assign load_active = cpu_rd && !cpu_wr;
   assign read_done   = (state_reg == READ) && mem_ack;
   assign pop         = (state_reg == WRITE) && mem_ack;
   assign any_match   = |match;
   // A load goes to memory only once nothing queued aliases its address.
   assign need_read   = load_active && !any_match;

   // ------------------------------------------------------------------
   // Per-entry validity and address match
   // ------------------------------------------------------------------
   // An entry is live when its distance from the head is below count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [PW-1:0] age;
         assign age             = PW'(gi) - head_reg;
         assign entry_valid[gi] = ({1'b0, age} < count_reg);
         assign match[gi]       = entry_valid[gi] && (addr_reg[gi] == cpu_addr);
      end
   endgenerate

`ifdef DMEM_WBUF_FWD_EN
   // Youngest match: walk from head (oldest) towards tail and keep the
   // last hit, which is the most recently pushed store to this address.
   logic [PW-1:0] young_idx;
   logic [PW-1:0] scan_idx;

   always_comb begin
      young_idx = head_reg;
      scan_idx  = head_reg;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_reg + PW'(k);
         if (match[scan_idx]) begin
            young_idx = scan_idx;
         end
      end
   end

   // Only a full-word youngest store can supply the whole load value; a
   // partial one would need merging with memory, so that case waits.
   assign fwd_hit  = load_active && any_match && (be_reg[young_idx] == 4'hF);
   assign fwd_data = data_reg[young_idx];
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // ------------------------------------------------------------------
   // Core-side response
   // ------------------------------------------------------------------
   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      if (!reset) begin
         if (cpu_wr) begin
            cpu_stall = full;
         end else if (cpu_rd) begin
            if (fwd_hit) begin
               cpu_rdata = fwd_data;
            end else if (read_done) begin
               cpu_rdata = mem_rdata;
            end else begin
               cpu_stall = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO pointer arithmetic
   // ------------------------------------------------------------------
   always_comb begin
      head_next  = pop  ? head_reg + PW'(1) : head_reg;
      tail_next  = push ? tail_reg + PW'(1) : tail_reg;
      count_next = count_reg + CW'(push) - CW'(pop);
   end

   // ------------------------------------------------------------------
   // Memory-side FSM: next state and next values of the mem_* registers
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      mem_be_next    = mem_be_reg;

      case (state_reg)
         IDLE: begin
            // A waiting load is served before draining so the core resumes
            // sooner; stores are posted and can afford to wait.
            if (need_read) begin
               state_next    = READ;
               mem_req_next  = 1'b1;
               mem_we_next   = 1'b0;
               mem_addr_next = cpu_addr;
               mem_be_next   = 4'hF;
            end else if (count_reg != '0) begin
               state_next     = WRITE;
               mem_req_next   = 1'b1;
               mem_we_next    = 1'b1;
               mem_addr_next  = addr_reg[head_reg];
               mem_wdata_next = data_reg[head_reg];
               mem_be_next    = be_reg[head_reg];
            end
         end

         // Outputs stay frozen until the ack; returning through IDLE
         // guarantees a one-cycle gap between transactions.
         WRITE: begin
            if (mem_ack) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
            end
         end

         READ: begin
            if (mem_ack) begin
               state_next   = IDLE;
               mem_req_next = 1'b0;
            end
         end

         default: begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // Reset discards queued stores and drops mem_req even mid-transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_be_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         count_reg     <= count_next;
         mem_req_reg   <= mem_req_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         mem_be_reg    <= mem_be_next;
      end
   end

   // Entry payload needs no reset: liveness comes from head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_reg[tail_reg] <= cpu_addr;
         data_reg[tail_reg] <= cpu_wdata;
         be_reg[tail_reg]   <= cpu_be;
      end
   end

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_be    = mem_be_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_dmem_wbuf.sv
// ---------------------------------------------------------------------------
// tb_dmem_wbuf -- self-checking bench for dmem_wbuf (DEPTH=4)
//
// The reference model keeps the queued stores as a queue of records and the
// memory contents as a sparse array. The value any load must return is the
// memory word with every queued store to that address merged over it in
// order. A responder acknowledges mem_req after a random or forced delay
// and can be told to withhold acks. Directed scenarios are followed by a
// randomized store/load mix over a small address window.
// ---------------------------------------------------------------------------
module tb_dmem_wbuf;

   localparam int DEPTH = 4;
`ifdef DMEM_WBUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   cpu_wr;
   logic                   cpu_rd;
   logic [29:0]            cpu_addr;
   logic [31:0]            cpu_wdata;
   logic [3:0]             cpu_be;
   logic [31:0]            cpu_rdata;
   logic                   cpu_stall;
   logic                   mem_req;
   logic                   mem_we;
   logic [29:0]            mem_addr;
   logic [31:0]            mem_wdata;
   logic [3:0]             mem_be;
   logic                   mem_ack;
   logic [31:0]            mem_rdata;
   logic [$clog2(DEPTH):0] count;

   dmem_wbuf #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_wr    (cpu_wr),
      .cpu_rd    (cpu_rd),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_be    (cpu_be),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } st_t;

   typedef struct {
      bit          we;
      logic [29:0] addr;
      logic [31:0] data;
   } txn_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   st_t         q[$];
   txn_t        log_q[$];
   logic [31:0] mem_model [logic [29:0]];
   int          allow_acks  = -1;
   int          force_delay = -1;
   int          dly         = 0;
   bit          busy        = 1'b0;
   bit          prev_done   = 1'b0;
   int          wr_done_cyc = -1;
   int          acc_cyc     = -1;
   bit          last_stall  = 1'b0;
   logic [31:0] last_rdata  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [29:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {2'b10, a} ^ 32'h5A5A_0000;
   endfunction

   // Value an in-order memory would hold once every queued store landed.
   function automatic logic [31:0] merged(input logic [29:0] a);
      logic [31:0] v;
      v = mem_val(a);
      foreach (q[i]) begin
         if (q[i].addr == a) begin
            for (int b = 0; b < 4; b++) begin
               if (q[i].be[b]) v[8*b +: 8] = q[i].data[8*b +: 8];
            end
         end
      end
      return v;
   endfunction

   // One clock cycle: check outputs at the negedge, update the model for
   // the coming edge, then let the responder drive mem_ack after the edge.
   task automatic tick(output bit acc);
      bit          any_m;
      bit          yfull;
      bit          done_now;
      logic [31:0] v;
      acc   = 1'b0;
      any_m = 1'b0;
      yfull = 1'b0;
      @(negedge clk);
      last_stall = cpu_stall;
      if (prev_done) check("idle_gap", mem_req, 1'b0);
      check("count", count, q.size());

      if (cpu_wr) begin
         check("wr_stall", cpu_stall, q.size() == DEPTH);
         acc = !cpu_stall;
      end else if (cpu_rd) begin
         foreach (q[i]) begin
            if (q[i].addr == cpu_addr) begin
               any_m = 1'b1;
               yfull = (q[i].be == 4'hF);
            end
         end
         if (any_m) check("match_stall", cpu_stall, !(FWD && yfull));
         else if (!cpu_stall)
            check("miss_ack", mem_req && !mem_we && mem_ack && (mem_addr == cpu_addr), 1'b1);
         if (!cpu_stall) begin
            check("rdata", cpu_rdata, merged(cpu_addr));
            acc        = 1'b1;
            last_rdata = cpu_rdata;
            $display("[TB] cyc=%0d load  addr=0x%0h data=0x%08h", cyc, cpu_addr, cpu_rdata);
         end
      end

      done_now = mem_req && mem_ack;
      if (done_now) begin
         if (mem_we) begin
            check("wr_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               check("wr_addr", mem_addr, q[0].addr);
               check("wr_data", mem_wdata, q[0].data);
               check("wr_be", mem_be, q[0].be);
               v = mem_val(q[0].addr);
               for (int b = 0; b < 4; b++) begin
                  if (q[0].be[b]) v[8*b +: 8] = q[0].data[8*b +: 8];
               end
               mem_model[q[0].addr] = v;
               void'(q.pop_front());
            end
            wr_done_cyc = cyc;
            log_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
            $display("[TB] cyc=%0d mem write addr=0x%0h data=0x%08h be=%b", cyc, mem_addr, mem_wdata, mem_be);
         end else begin
            check("rd_be", mem_be, 4'hF);
            any_m = 1'b0;
            foreach (q[i]) if (q[i].addr == mem_addr) any_m = 1'b1;
            check("rd_no_alias", any_m, 1'b0);
            log_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
            $display("[TB] cyc=%0d mem read  addr=0x%0h data=0x%08h", cyc, mem_addr, mem_rdata);
         end
      end

      if (cpu_wr && acc) begin
         q.push_back('{addr: cpu_addr, data: cpu_wdata, be: cpu_be});
         acc_cyc = cyc;
         $display("[TB] cyc=%0d store addr=0x%0h data=0x%08h be=%b", cyc, cpu_addr, cpu_wdata, cpu_be);
      end
      prev_done = done_now;

      @(posedge clk);
      #1;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req) begin
         if (!busy) begin
            busy = 1'b1;
            dly  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
         end
         if (allow_acks != 0) begin
            if (dly == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_we ? $urandom : mem_val(mem_addr);
               busy      = 1'b0;
               if (allow_acks > 0) allow_acks--;
            end else begin
               dly--;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_store(input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int n);
      bit acc;
      cpu_wr    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_be    = be;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
         tick(acc);
         n++;
      end
      if (!acc) check("store_timeout", acc, 1'b1);
      cpu_wr = 1'b0;
   endtask

   task automatic do_load(input logic [29:0] a, output int n);
      bit acc;
      cpu_wr   = 1'b0;
      cpu_rd   = 1'b1;
      cpu_addr = a;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
         tick(acc);
         n++;
      end
      if (!acc) check("load_timeout", acc, 1'b1);
      cpu_rd = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while ((q.size() != 0 || mem_req) && n < 500) begin
         tick(acc);
         n++;
      end
      check("drain_empty", q.size(), 0);
      check("drain_count", count, 0);
   endtask

   // Holds reset with a load request present, then checks every output.
   task automatic do_reset(input int ncyc);
      reset    = 1'b1;
      cpu_wr   = 1'b0;
      cpu_rd   = 1'b1;
      cpu_addr = 30'h123;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         check("rst_stall", cpu_stall, 1'b0);
         check("rst_rdata", cpu_rdata, 32'h0);
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
      end
      reset     = 1'b0;
      cpu_rd    = 1'b0;
      q.delete();
      busy      = 1'b0;
      prev_done = 1'b0;
      @(negedge clk);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 30'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", mem_be, 4'h0);
      check("rst_count", count, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      bit          acc;
      int          rd_n;
      int          r;
      logic [29:0] a;

      reset     = 1'b1;
      cpu_wr    = 1'b0;
      cpu_rd    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_be    = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      do_reset(3);

      // Fill with acks withheld, fifth store stalls until one write lands.
      allow_acks = 0;
      log_q.delete();
      for (int i = 0; i < 4; i++) begin
         do_store(30'h10 + 30'(i), 32'h1000 + 32'(i), 4'hF, n);
         check("fill_latency", n, 1);
      end
      cpu_wr    = 1'b1;
      cpu_addr  = 30'h14;
      cpu_wdata = 32'h1004;
      cpu_be    = 4'hF;
      tick(acc);
      check("full_acc", acc, 1'b0);
      check("full_stall", last_stall, 1'b1);
      check("full_count", count, 4);
      allow_acks  = 1;
      wr_done_cyc = -1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         tick(acc);
         n++;
      end
      cpu_wr = 1'b0;
      check("full_accept", acc, 1'b1);
      check("full_accept_cyc", acc_cyc, wr_done_cyc + 1);
      check("full_one_write", log_q.size(), 1);
      if (log_q.size() > 0) check("full_first_addr", log_q[0].addr, 30'h10);
      allow_acks = -1;
      drain();

      // Ordered drain with a fixed ack delay.
      log_q.delete();
      force_delay = 2;
      do_store(30'h20, 32'hDEADBEEF, 4'hF, n);
      do_store(30'h21, 32'h12345678, 4'hF, n);
      drain();
      check("order_len", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("order_a_addr", log_q[0].addr, 30'h20);
         check("order_a_data", log_q[0].data, 32'hDEADBEEF);
         check("order_b_addr", log_q[1].addr, 30'h21);
         check("order_b_data", log_q[1].data, 32'h12345678);
      end
      force_delay = -1;

      // Load to another address overtakes a queued store.
      log_q.delete();
      mem_model[30'h40] = 32'hCAFEF00D;
      do_store(30'h30, 32'h3030_3030, 4'hF, n);
      do_load(30'h40, n);
      check("bypass_rdata", last_rdata, 32'hCAFEF00D);
      drain();
      check("bypass_len", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("bypass_first_rd", log_q[0].we, 1'b0);
         check("bypass_first_addr", log_q[0].addr, 30'h40);
         check("bypass_then_wr", log_q[1].addr, 30'h30);
      end

      // Full-word match: forwarded or stalled depending on the build.
      log_q.delete();
      force_delay = 1;
      do_store(30'h50, 32'hA5A5A5A5, 4'hF, n);
      do_load(30'h50, n);
      check("fwd_rdata", last_rdata, 32'hA5A5A5A5);
      drain();
      rd_n = 0;
      foreach (log_q[i]) if (!log_q[i].we) rd_n++;
`ifdef DMEM_WBUF_FWD_EN
      check("fwd_latency", n, 1);
      check("fwd_no_read", rd_n, 0);
`else
      check("nofwd_stalled", n > 1, 1'b1);
      check("nofwd_one_read", rd_n, 1);
      if (log_q.size() == 2) begin
         check("nofwd_wr_first", log_q[0].we, 1'b1);
         check("nofwd_rd_addr", log_q[1].addr, 30'h50);
      end
`endif

      // Partial-enable match always waits for the write, then reads.
      log_q.delete();
      mem_model[30'h60] = 32'h11223344;
      do_store(30'h60, 32'h0000BEEF, 4'b0011, n);
      do_load(30'h60, n);
      check("partial_rdata", last_rdata, 32'h1122BEEF);
      check("partial_stalled", n > 1, 1'b1);
      drain();
      check("partial_len", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("partial_wr_first", log_q[0].we, 1'b1);
         check("partial_rd_second", log_q[1].we, 1'b0);
         check("partial_rd_addr", log_q[1].addr, 30'h60);
      end

      // mem_req rises one cycle after the push edge.
      do_store(30'h90, 32'h9090_9090, 4'hF, n);
      check("push_req_low", mem_req, 1'b0);
      tick(acc);
      check("push_req_high", mem_req, 1'b1);
      drain();

      // Minimum load-miss latency with ack in the first request cycle.
      force_delay = 0;
      do_load(30'h44, n);
      check("miss_latency", n, 2);

      // Reset while a write is outstanding.
      allow_acks = 0;
      do_store(30'h70, 32'h7777_7777, 4'hF, n);
      n = 0;
      while (!mem_req && n < 10) begin
         tick(acc);
         n++;
      end
      check("midwr_req", mem_req, 1'b1);
      do_reset(1);
      allow_acks  = -1;
      force_delay = 0;
      do_load(30'h70, n);
      check("midwr_load_latency", n, 2);
      check("midwr_load_data", last_rdata, mem_val(30'h70));
      force_delay = -1;

      // Randomized mix over a small address window so aliasing is common.
      for (int it = 0; it < 400; it++) begin
         r = int'($urandom_range(0, 9));
         a = 30'h200 + 30'($urandom_range(0, 5));
         if (r < 4) begin
            cpu_rd = ($urandom_range(0, 3) == 0);
            do_store(a, $urandom, 4'($urandom_range(1, 15)), n);
            cpu_rd = 1'b0;
         end else if (r < 7) begin
            do_load(a, n);
         end else begin
            tick(acc);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
